// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds a baud-rate serialiser driving txd (LSB first).
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic push, pop, fifo_empty, cnt_end;

  assign wr_ready   = (count_q != DEPTH_C);
  assign push       = wr_valid && wr_ready;
  assign fifo_empty = (count_q == '0);
  assign cnt_end    = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: if (cnt_end) begin
        cnt_d   = '0;
        state_d = DATA;
        txd_d   = shift_q[0];
      end
      DATA: if (cnt_end) begin
        cnt_d   = '0;
        shift_d = shift_q >> 1;
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          txd_d   = parity_q;
`else
          state_d = STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
          txd_d = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (cnt_end) begin
        cnt_d   = '0;
        state_d = STOP;
        txd_d   = 1'b1;
      end
`endif
      STOP: if (cnt_end) begin
        cnt_d = '0;
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
        end else begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // NOTE: storage is left unreset; an entry is only read after a push wrote it, and reset clears the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clocks per bit, FIFO_DEPTH=4.
// Define UART_TX_PARITY_EN for both files to exercise the parity build.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB   = 16;
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;
  int t0          = 0;

  uart_tx_fifo #(.CLK_FREQ_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NB-1:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Returns at the falling edge following edge number t0+e.
  task automatic wait_edge(input int e);
    @(negedge clk);
    while (edge_cnt < t0 + e) @(negedge clk);
  endtask

  task automatic align;
    @(posedge clk);
    #1;
    t0 = edge_cnt + 1;
  endtask

  task automatic push_hold(input logic [7:0] b, input int bound);
    logic r;
    r        = 1'b0;
    wr_data  = b;
    wr_valid = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      r = wr_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    wr_valid = 1'b0;
    if (!r) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: byte %h not accepted within %0d cycles", b, bound);
    end
  endtask

  task automatic rx_frame(input int f, input logic [NB-1:0] exp, input string nm);
    logic [NB-1:0] got;
    for (int i = 0; i < NB; i++) begin
      wait_edge(1 + FRAME * f + CPB * i + CPB / 2);
      got[i] = txd;
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: line bits %b, expected %b", nm, got, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    vectors++;
    if ({txd, busy, wr_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL %s: txd=%b busy=%b wr_ready=%b count=%0d, expected 1 0 1 0",
               nm, txd, busy, wr_ready, fifo_count);
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    #1;
    check_idle("reset_values");
    #21 reset = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_idle("idle_50");
  endtask

  task automatic test_single;
    align();
    push_hold(8'h55, 4);
    @(negedge clk);
    vectors++;
    if ({txd, busy, fifo_count} !== {1'b1, 1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL accept_edge0: txd=%b busy=%b count=%0d, expected 1 1 1", txd, busy, fifo_count);
    end
    wait_edge(1);
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL start_latency: txd=%b, expected 0", txd);
    end
    rx_frame(0, exp_frame(8'h55), "frame_55");
`ifndef UART_TX_PARITY_EN
    vectors++;
    if (exp_frame(8'h55) !== 10'b1010101010) begin
      miscompares++;
      $display("FAIL model_55: model %b, expected 1010101010", exp_frame(8'h55));
    end
`endif
    wait_edge(FRAME);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_last_stop: busy=%b, expected 1", busy);
    end
    wait_edge(FRAME + 1);
    check_idle("busy_fall");
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [6];
    int acc_edge;
    bytes = '{8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h81, 8'h3C};
    align();
    fork
      begin
        for (int i = 0; i < 5; i++) push_hold(bytes[i], 4);
        @(negedge clk);
        vectors++;
        if ({wr_ready, fifo_count} !== {1'b0, 3'd4}) begin
          miscompares++;
          $display("FAIL full_after_5: wr_ready=%b count=%0d, expected 0 4", wr_ready, fifo_count);
        end
        push_hold(bytes[5], 2 * FRAME);
        acc_edge = edge_cnt - t0;
        vectors++;
        if (acc_edge != FRAME + 2) begin
          miscompares++;
          $display("FAIL stall_release: 6th push at edge %0d, expected %0d", acc_edge, FRAME + 2);
        end
      end
      begin
        for (int f = 0; f < 6; f++) rx_frame(f, exp_frame(bytes[f]), $sformatf("b2b_frame%0d", f));
      end
    join
    wait_edge(6 * FRAME + 1);
    check_idle("b2b_drain");
  endtask

  task automatic test_full_pop;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    align();
    fork
      begin
        for (int i = 0; i < 5; i++) push_hold(bytes[i], 4);
        wr_data  = bytes[5];
        wr_valid = 1'b1;
        wait_edge(FRAME);
        vectors++;
        if ({wr_ready, fifo_count} !== {1'b0, 3'd4}) begin
          miscompares++;
          $display("FAIL full_before_pop: wr_ready=%b count=%0d, expected 0 4", wr_ready, fifo_count);
        end
        wait_edge(FRAME + 1);
        vectors++;
        if ({wr_ready, fifo_count} !== {1'b1, 3'd3}) begin
          miscompares++;
          $display("FAIL pop_edge: wr_ready=%b count=%0d, expected 1 3", wr_ready, fifo_count);
        end
        wait_edge(FRAME + 2);
        wr_valid = 1'b0;
        vectors++;
        if ({wr_ready, fifo_count} !== {1'b0, 3'd4}) begin
          miscompares++;
          $display("FAIL refill_edge: wr_ready=%b count=%0d, expected 0 4", wr_ready, fifo_count);
        end
      end
      begin
        for (int f = 0; f < 6; f++) rx_frame(f, exp_frame(bytes[f]), $sformatf("full_frame%0d", f));
      end
    join
    wait_edge(6 * FRAME + 1);
    check_idle("full_drain");
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    align();
    push_hold(8'hC6, 4);
    push_hold(8'h5A, 4);
    push_hold(8'h96, 4);
    wait_edge(70);
    vectors++;
    if ({txd, fifo_count} !== {1'b0, 3'd2}) begin
      miscompares++;
      $display("FAIL data_bit3: txd=%b count=%0d, expected 0 2", txd, fifo_count);
    end
    #2 reset = 1'b1;
    #1;
    check_idle("async_reset");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL no_resume: %0d non-idle cycles after reset, expected 0", bad);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    align();
    fork
      begin
        push_hold(8'h07, 4);
        push_hold(8'h03, 4);
      end
      begin
        rx_frame(0, 11'b110_0000_1110, "parity_07");
        rx_frame(1, 11'b100_0000_0110, "parity_03");
      end
    join
    wait_edge(2 * FRAME);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_len: busy=%b at edge %0d, expected 1", busy, 2 * FRAME);
    end
    wait_edge(2 * FRAME + 1);
    check_idle("parity_drain");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
